// File: rtl/fence_wfi_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fence_wfi_seq_pkg
// Purpose  : Shared encodings for the FENCE / FENCE.I / WFI sequencer:
//            FSM state codes (also exported on Seq_State for debug) and the
//            latched instruction kind.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package fence_wfi_seq_pkg;

  localparam int SEQ_STATE_WIDTH = 3;

  // Codes 6 and 7 are unused; the FSM recovers from them to SEQ_IDLE.
  typedef enum logic [SEQ_STATE_WIDTH-1:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_DRAIN  = 3'd1,
    SEQ_DFLUSH = 3'd2,
    SEQ_IINV   = 3'd3,
    SEQ_SLEEP  = 3'd4,
    SEQ_DONE   = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_FENCE  = 2'd1,
    KIND_FENCEI = 2'd2,
    KIND_WFI    = 2'd3
  } seq_kind_e;

endpackage
`default_nettype wire

// File: rtl/fence_wfi_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fence_wfi_seq_if
// Purpose  : Bundles the decode, pipeline-occupancy, cache handshake and CSR
//            signals seen by the fence/WFI sequencer.
// Modports : master - the sequencer (consumes decode/status, drives requests)
//            slave  - the surrounding core/caches
// Revision : 1.0  initial release
// ============================================================================
interface fence_wfi_seq_if;
  import fence_wfi_seq_pkg::*;

  logic                       Decode_Fence;
  logic                       Decode_FenceI;
  logic                       Decode_Wfi;
  logic                       EX_LdStFlag;
  logic                       Mem_LdStFlag;
  logic                       Dcache_Busy;
  logic                       Dcache_FlushAck;
  logic                       Icache_InvAck;
  logic                       Csr_IntPending;
  logic                       Csr_WFIClrFlag;
  logic                       Csr_ExcpFlag;
  logic                       Seq_StallReq;
  logic                       Dcache_FlushReq;
  logic                       Icache_InvReq;
  logic                       Seq_Done;
  logic                       Seq_Refetch;
  logic                       Seq_Timeout;
  logic [SEQ_STATE_WIDTH-1:0] Seq_State;

  modport master (
    input  Decode_Fence, Decode_FenceI, Decode_Wfi,
    input  EX_LdStFlag, Mem_LdStFlag, Dcache_Busy,
    input  Dcache_FlushAck, Icache_InvAck,
    input  Csr_IntPending, Csr_WFIClrFlag, Csr_ExcpFlag,
    output Seq_StallReq, Dcache_FlushReq, Icache_InvReq,
    output Seq_Done, Seq_Refetch, Seq_Timeout, Seq_State
  );

  modport slave (
    output Decode_Fence, Decode_FenceI, Decode_Wfi,
    output EX_LdStFlag, Mem_LdStFlag, Dcache_Busy,
    output Dcache_FlushAck, Icache_InvAck,
    output Csr_IntPending, Csr_WFIClrFlag, Csr_ExcpFlag,
    input  Seq_StallReq, Dcache_FlushReq, Icache_InvReq,
    input  Seq_Done, Seq_Refetch, Seq_Timeout, Seq_State
  );

endinterface
`default_nettype wire

// File: rtl/fence_wfi_seq.sv
`default_nettype none
// ============================================================================
// Module   : fence_wfi_seq
// Purpose  : Multi-cycle sequencer for FENCE, FENCE.I and WFI. Drains
//            in-flight memory ops (with timeout), handshakes D-cache
//            write-back and I-cache invalidate, and parks the core in WFI.
// Ports    : clk  - core clock
//            rst  - asynchronous active-high reset
//            bus  - fence_wfi_seq_if.master (decode, occupancy, cache
//                   handshakes, CSR wake/exception in; stall, cache
//                   requests, done/refetch/timeout pulses, state out)
// Params   : DRAIN_TIMEOUT      - max DRAIN cycles before forced exit (>=2)
//            FENCE_FLUSH_DCACHE - plain FENCE also writes back the D-cache
// Revision : 1.0  initial release
// ============================================================================
module fence_wfi_seq
  import fence_wfi_seq_pkg::*;
#(
  parameter int DRAIN_TIMEOUT      = 256,
  parameter bit FENCE_FLUSH_DCACHE = 1'b0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  fence_wfi_seq_if.master bus
);

  localparam int               CNT_W   = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_e       state_q, state_d;
  seq_kind_e        kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             flush_req_q, flush_req_d;
  logic             inv_req_q, inv_req_d;

  logic drained;
  logic decode_any;
  logic stall;
  logic done;
  logic refetch;
  logic timeout;

  // Where DRAIN goes once the pipeline is empty (or the drain timed out).
  function automatic seq_state_e drain_exit(seq_kind_e k);
    seq_state_e nxt;
    nxt = SEQ_DONE;
    if (k == KIND_FENCEI || (k == KIND_FENCE && FENCE_FLUSH_DCACHE))
      nxt = SEQ_DFLUSH;
    else if (k == KIND_WFI)
      nxt = SEQ_SLEEP;
    return nxt;
  endfunction

  assign drained    = !bus.EX_LdStFlag && !bus.Mem_LdStFlag && !bus.Dcache_Busy;
  assign decode_any = (bus.Decode_Wfi || bus.Decode_FenceI || bus.Decode_Fence)
                      && !bus.Csr_ExcpFlag;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    stall   = 1'b0;
    done    = 1'b0;
    refetch = 1'b0;
    timeout = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        // Stall in the decode cycle itself so no younger op slips past.
        stall = decode_any;
        if (decode_any) begin
          state_d = SEQ_DRAIN;
          cnt_d   = '0;
          if (bus.Decode_Wfi)         kind_d = KIND_WFI;
          else if (bus.Decode_FenceI) kind_d = KIND_FENCEI;
          else                        kind_d = KIND_FENCE;
        end
      end

      SEQ_DRAIN: begin
        stall = 1'b1;
        if (bus.Csr_ExcpFlag) begin
          state_d = SEQ_IDLE;
          kind_d  = KIND_NONE;
        end else if (drained || cnt_q == CNT_SAT) begin
          // Reaching the saturation value while still busy is a forced exit.
          timeout = !drained;
          state_d = drain_exit(kind_q);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      SEQ_DFLUSH, SEQ_IINV: begin
        // The cache request cannot be withdrawn, so an exception here is
        // only remembered and acted on once the ack arrives.
        stall = 1'b1;
        if (bus.Csr_ExcpFlag) abort_d = 1'b1;
        if ((state_q == SEQ_DFLUSH) ? bus.Dcache_FlushAck : bus.Icache_InvAck) begin
          if (abort_q || bus.Csr_ExcpFlag) begin
            state_d = SEQ_IDLE;
            kind_d  = KIND_NONE;
            abort_d = 1'b0;
          end else if (state_q == SEQ_DFLUSH && kind_q == KIND_FENCEI) begin
            state_d = SEQ_IINV;
          end else begin
            state_d = SEQ_DONE;
          end
        end
      end

      SEQ_SLEEP: begin
        stall = 1'b1;
        if (bus.Csr_ExcpFlag) begin
          state_d = SEQ_IDLE;
          kind_d  = KIND_NONE;
        end else if (bus.Csr_IntPending || bus.Csr_WFIClrFlag) begin
          state_d = SEQ_DONE;
        end
      end

      SEQ_DONE: begin
        done    = 1'b1;
        refetch = (kind_q == KIND_FENCEI);
        state_d = SEQ_IDLE;
        kind_d  = KIND_NONE;
      end

      default: begin
        state_d = SEQ_IDLE;
        kind_d  = KIND_NONE;
        abort_d = 1'b0;
      end
    endcase

    // Requests are registered and track the state they belong to.
    flush_req_d = (state_d == SEQ_DFLUSH);
    inv_req_d   = (state_d == SEQ_IINV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEQ_IDLE;
      kind_q      <= KIND_NONE;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      flush_req_q <= 1'b0;
      inv_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      flush_req_q <= flush_req_d;
      inv_req_q   <= inv_req_d;
    end
  end

  // The IDLE stall term is combinational from decode; mask it during reset.
  assign bus.Seq_StallReq    = stall && !rst;
  assign bus.Dcache_FlushReq = flush_req_q;
  assign bus.Icache_InvReq   = inv_req_q;
  assign bus.Seq_Done        = done;
  assign bus.Seq_Refetch     = refetch;
  assign bus.Seq_Timeout     = timeout;
  assign bus.Seq_State       = state_q;

endmodule
`default_nettype wire
